shift_left_seq_32: RTL and testbench
====================================

# shift_left_seq_32

Sequential multi-bit left shifter that sits directly downstream of the single-bit `shift_left_32` stage. It performs an N-bit shift as N registered one-bit shift steps, with the same `a`/`cin`/`cout`/`en` semantics. Each step feeds `cout` forward and fills the LSB with the captured carry-in. It gives the datapath a variable shift of 0–31 positions with a start/busy/done handshake and a stall input, without a 32-way barrel mux.

## Interface
- `WIDTH`, 32: data width. The bench and the integration use 32 only.
- `AMT_W`, 5: shift-amount width. Must equal log2(WIDTH).

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request a shift. Accepted only in IDLE.
- `a`  in  WIDTH  operand. Captured on an accepted `start`.
- `amt`  in  AMT_W  number of 1-bit shifts, 0–31. Captured on an accepted `start`.
- `cin`  in  1  LSB fill bit for every step. Captured on an accepted `start`.
- `en`  in  1  step enable. Only sampled in SHIFT. When low, the shift stalls.
- `b`  out  WIDTH  shifted result, registered
- `cout`  out  1  last bit shifted out of the MSB, registered
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse: `b` and `cout` are final

## Operation
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `b`=0, `cout`=0, `busy`=0, `done`=0.
  - Internal count = 0, captured cin = 0.
- States: IDLE, SHIFT, DONE.
- IDLE with `start`=1 (the accepting edge, E0):
  - Load `b`←`a`, count←`amt`, cin_q←`cin`, `cout`←0.
  - Next state is SHIFT if `amt`≠0, otherwise DONE.
- IDLE with `start`=0: hold all registers.
- SHIFT with `en`=1, at each edge:
  - `cout`←`b[WIDTH-1]`
  - `b`←{`b[WIDTH-2:0]`, cin_q}
  - count←count−1
  - When count is 1 at this edge, the next state is DONE.
- SHIFT with `en`=0: hold `b`, `cout` and count. Stay in SHIFT.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE. `b` and `cout` hold.
- `start` while `busy`=1 (SHIFT or DONE) is ignored. Nothing is queued and the captured operands are unaffected.
- `b` and `cout` hold their final values through IDLE until the next accepted `start`.
- `amt`=0: the result is `b`=`a` and `cout`=0.
- No arithmetic wrap: count is AMT_W bits and never decrements below 1 inside SHIFT.

## Timing
- `done` and `busy` are decoded from state registers. They are glitch-free and change only on `clk` edges or reset.
- Let E0 be the start edge. With no stalls:
  - `done` rises at edge E(amt) and falls at E(amt+1).
  - For `amt`=0, `done` rises at E0.
- Each `en`=0 cycle in SHIFT delays `done` by one cycle.
- `busy` is high from E0 until the edge where DONE exits, i.e. for amt+1 cycles plus stalls.
- The earliest next `start` is accepted at the edge after `done` falls. Back-to-back throughput is one operation per amt+2 cycles.
- `rst_n` asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - No `done` pulse is issued.
  - After `rst_n` deasserts, the first rising edge with `start`=1 is accepted normally.

## Test plan
- `a`=0x000F000F, `amt`=4, `cin`=1, `en`=1 → `done` at E4, `b`=0x00F000FF, `cout`=0, `busy` high for 5 cycles.
- `a`=0xF000F37E, `amt`=1, `cin`=0 → `done` at E1, `b`=0xE001E6FC, `cout`=1.
- `a`=0x00FF0010, `amt`=0, `cin`=1 → `done` at E0 (next cycle), `b`=0x00FF0010, `cout`=0. A second `start` asserted with `done` is ignored.
- `a`=0x0FF00FF0, `amt`=8, `cin`=1, with `en` low for 3 cycles after E2 → `done` at E11, `b`=0xF00FF0FF, `cout`=1. `b` is held constant during the stall.
- `a`=0x00000003, `amt`=31, `cin`=0 → `done` at E31, `b`=0x80000000, `cout`=1. Boundary case: maximum amount.
- Start `a`=0xFFFFFFFF, `amt`=10, then pull `rst_n` low after E5 → `b`=0, `cout`=0, `busy`=0 immediately, and no `done`. After release, `a`=0x1, `amt`=2, `cin`=0 gives `b`=0x4 with `done` at E2.

Source files
------------

// File: rtl/shift_left_seq_32.sv
// rtl/shift_left_seq_32.sv - sequential left shifter, one registered bit step per enabled cycle
// Shifts a by amt positions with cin fill, start/busy/done handshake and en stall.
module shift_left_seq_32 #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             cin,
   input  logic             en,
   output logic [WIDTH-1:0] b,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_b;
   logic               r_cout;
   logic [AMT_W-1:0]   r_cnt;
   logic               r_cin;
   logic               r_busy;
   logic               r_done;
   logic               w_accept;
   logic               w_step;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_step   = (r_state == ST_SHIFT) && en;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (amt != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            // count reaches 1 on the final step, so it never wraps through zero
            if (en && (r_cnt == AMT_W'(1))) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b    <= '0;
         r_cout <= 1'b0;
         r_cnt  <= '0;
         r_cin  <= 1'b0;
      end else if (w_accept) begin
         r_b    <= a;
         r_cout <= 1'b0;
         r_cnt  <= amt;
         r_cin  <= cin;
      end else if (w_step) begin
         r_b    <= {r_b[WIDTH-2:0], r_cin};
         r_cout <= r_b[WIDTH-1];
         r_cnt  <= r_cnt - AMT_W'(1);
      end
   end

   // Status flags are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
         r_done <= (w_state_nxt == ST_DONE);
      end
   end

   assign b    = r_b;
   assign cout = r_cout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_shift_left_seq_32.sv
// tb/tb_shift_left_seq_32.sv - directed self-checking bench for shift_left_seq_32
module tb_shift_left_seq_32;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [4:0]  amt;
   logic        cin;
   logic        en;
   logic [31:0] b;
   logic        cout;
   logic        busy;
   logic        done;

   int checks;
   int failures;

   shift_left_seq_32 #(.WIDTH(32), .AMT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .amt   (amt),
      .cin   (cin),
      .en    (en),
      .b     (b),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
   task automatic run_op(input logic [31:0] ia, input logic [4:0] iamt, input logic ic,
                         input int st_at, input int st_len,
                         output int lat, output int bcyc, output logic [31:0] bmid);
      int k;
      a = ia; amt = iamt; cin = ic; en = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0; bcyc = 0; bmid = '0;
      while (k < 200) begin
         if (busy) bcyc++;
         if (k == st_at) en = 1'b0;
         if (k == st_at + st_len) begin
            bmid = b;
            en = 1'b1;
         end
         if (done) break;
         @(negedge clk);
         k++;
      end
      en = 1'b1;
      lat = k;
   endtask

   task automatic step_after_done(input string tag, input int exp_busy);
      int bc;
      bc = exp_busy;
      @(negedge clk);
      chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
      bc = 0;
   endtask

   initial begin
      int lat, bcyc, saw_done;
      logic [31:0] bmid;
      checks = 0; failures = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; amt = '0; cin = 1'b0; en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_b", b, 32'h0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // amt=4, cin=1
      run_op(32'h000F000F, 5'd4, 1'b1, -1, 0, lat, bcyc, bmid);
      chk("t1_lat", lat, 32'd4);
      chk("t1_b", b, 32'h00F000FF);
      chk("t1_cout", {31'd0, cout}, 32'd0);
      chk("t1_busy_cycles", bcyc, 32'd5);
      step_after_done("t1", 5);
      repeat (3) @(negedge clk);
      chk("t1_hold_idle", b, 32'h00F000FF);

      // amt=1, cin=0
      run_op(32'hF000F37E, 5'd1, 1'b0, -1, 0, lat, bcyc, bmid);
      chk("t2_lat", lat, 32'd1);
      chk("t2_b", b, 32'hE001E6FC);
      chk("t2_cout", {31'd0, cout}, 32'd1);
      step_after_done("t2", 2);

      // amt=0, then a start during done must be ignored
      run_op(32'h00FF0010, 5'd0, 1'b1, -1, 0, lat, bcyc, bmid);
      chk("t3_lat", lat, 32'd0);
      chk("t3_b", b, 32'h00FF0010);
      chk("t3_cout", {31'd0, cout}, 32'd0);
      a = 32'hDEADBEEF; amt = 5'd3; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t3_ign_busy", {31'd0, busy}, 32'd0);
      chk("t3_ign_done", {31'd0, done}, 32'd0);
      repeat (4) @(negedge clk);
      chk("t3_ign_b", b, 32'h00FF0010);
      chk("t3_ign_busy2", {31'd0, busy}, 32'd0);

      // amt=8 with en low for the three edges following E2
      run_op(32'h0FF00FF0, 5'd8, 1'b1, 2, 3, lat, bcyc, bmid);
      chk("t4_lat", lat, 32'd11);
      chk("t4_stall_b", bmid, 32'h3FC03FC3);
      chk("t4_b", b, 32'hF00FF0FF);
      chk("t4_cout", {31'd0, cout}, 32'd1);
      chk("t4_busy_cycles", bcyc, 32'd12);
      step_after_done("t4", 12);

      // maximum amount
      run_op(32'h00000003, 5'd31, 1'b0, -1, 0, lat, bcyc, bmid);
      chk("t5_lat", lat, 32'd31);
      chk("t5_b", b, 32'h80000000);
      chk("t5_cout", {31'd0, cout}, 32'd1);
      step_after_done("t5", 32);

      // reset mid-operation
      a = 32'hFFFFFFFF; amt = 5'd10; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_pre_b", b, 32'hFFFFFFFF);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_b", b, 32'h0);
      chk("t6_rst_cout", {31'd0, cout}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      saw_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      chk("t6_no_done", saw_done, 32'd0);
      rst_n = 1'b1;
      run_op(32'h00000001, 5'd2, 1'b0, -1, 0, lat, bcyc, bmid);
      chk("t6_lat", lat, 32'd2);
      chk("t6_b", b, 32'h00000004);
      chk("t6_cout", {31'd0, cout}, 32'd0);
      step_after_done("t6", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
